// File: rtl/tap_read_interconnect_n_if.sv
// Read-side bus between the DMI TAP, the DMI read source and the strobe channels.
// The slave modport is the interconnect; master is the TAP and source side.
interface tap_read_interconnect_n_if #(
    parameter int unsigned IRLENGTH         = 5,
    parameter int unsigned READ_WIDTH       = 41,
    parameter int unsigned DMI_WIDTH        = 41,
    parameter int unsigned STB_STATUS_WIDTH = 8,
    parameter int unsigned STB_DATA_WIDTH   = 32,
    parameter int unsigned NUM_STB          = 4
);
    logic [IRLENGTH-1:0]                 READ_ADDRESS_I;
    logic                                READ_READY_I;
    logic                                READ_VALID_O;
    logic [READ_WIDTH-1:0]               READ_DATA_O;
    logic [(1 << IRLENGTH)-1:0]          VALID_ADDRESS_O;
    logic                                DMI_READ_VALID_I;
    logic                                DMI_READ_READY_O;
    logic [DMI_WIDTH-1:0]                DMI_READ_DATA_I;
    logic [NUM_STB-1:0]                  STB_STATUS_VALID_I;
    logic [NUM_STB-1:0]                  STB_STATUS_READY_O;
    logic [NUM_STB*STB_STATUS_WIDTH-1:0] STB_STATUS_I;
    logic [NUM_STB-1:0]                  STB_DATA_VALID_I;
    logic [NUM_STB-1:0]                  STB_DATA_READY_O;
    logic [NUM_STB*STB_DATA_WIDTH-1:0]   STB_DATA_I;

    modport slave (
        input  READ_ADDRESS_I, READ_READY_I,
        output READ_VALID_O, READ_DATA_O, VALID_ADDRESS_O,
        input  DMI_READ_VALID_I, DMI_READ_DATA_I,
        output DMI_READ_READY_O,
        input  STB_STATUS_VALID_I, STB_STATUS_I,
        output STB_STATUS_READY_O,
        input  STB_DATA_VALID_I, STB_DATA_I,
        output STB_DATA_READY_O
    );

    modport master (
        output READ_ADDRESS_I, READ_READY_I,
        input  READ_VALID_O, READ_DATA_O, VALID_ADDRESS_O,
        output DMI_READ_VALID_I, DMI_READ_DATA_I,
        input  DMI_READ_READY_O,
        output STB_STATUS_VALID_I, STB_STATUS_I,
        input  STB_STATUS_READY_O,
        output STB_DATA_VALID_I, STB_DATA_I,
        input  STB_DATA_READY_O
    );
endinterface

// File: rtl/tap_read_interconnect_n.sv
// One-entry capture buffers for the DMI and strobe read streams, with a two-state
// FSM that hands buffered words back to the TAP over valid/ready.
module tap_read_interconnect_n #(
    parameter int unsigned IRLENGTH         = 5,
    parameter int unsigned READ_WIDTH       = 41,
    parameter int unsigned DMI_WIDTH        = 41,
    parameter int unsigned STB_STATUS_WIDTH = 8,
    parameter int unsigned STB_DATA_WIDTH   = 32,
    parameter int unsigned NUM_STB          = 4,
    parameter int unsigned DMI_ADDR         = 'h11,
    parameter int unsigned STB_BASE         = 'h04
) (
    input  logic                         CLK_I,
    input  logic                         RST_NI,
    tap_read_interconnect_n_if.slave     bus
);
    // Buffer 0 is DMI; buffers 2k+1 / 2k+2 are status / data of strobe channel k.
    localparam int unsigned NUM_BUF = 1 + 2 * NUM_STB;
    localparam int unsigned ADDR_N  = 1 << IRLENGTH;

    typedef enum logic {IDLE, SEND} state_t;

    state_t                                 state_q, state_d;
    logic [NUM_BUF-1:0]                     src_valid;
    logic [READ_WIDTH-1:0]                  src_word [NUM_BUF];
    logic [NUM_BUF-1:0]                     buf_full;
    logic [NUM_BUF-1:0]                     sel_oh;
    logic [NUM_BUF-1:0]                     clr;
    logic [READ_WIDTH-1:0][NUM_BUF-1:0]     rd_col;
    logic [READ_WIDTH-1:0]                  hit_word;
    logic                                   hit_full;
    logic                                   mapped;
    logic                                   load;
    logic [READ_WIDTH-1:0]                  load_word;
    logic [READ_WIDTH-1:0]                  resp_data_p0;

    assign src_valid[0]         = bus.DMI_READ_VALID_I;
    assign src_word[0]          = READ_WIDTH'(bus.DMI_READ_DATA_I);
    assign bus.DMI_READ_READY_O = !buf_full[0];

    for (genvar k = 0; k < NUM_STB; k++) begin : g_stb_src
        assign src_valid[2*k+1]          = bus.STB_STATUS_VALID_I[k];
        assign src_valid[2*k+2]          = bus.STB_DATA_VALID_I[k];
        assign src_word[2*k+1]           = READ_WIDTH'(bus.STB_STATUS_I[k*STB_STATUS_WIDTH +: STB_STATUS_WIDTH]);
        assign src_word[2*k+2]           = READ_WIDTH'(bus.STB_DATA_I[k*STB_DATA_WIDTH +: STB_DATA_WIDTH]);
        assign bus.STB_STATUS_READY_O[k] = !buf_full[2*k+1];
        assign bus.STB_DATA_READY_O[k]   = !buf_full[2*k+2];
    end

    for (genvar i = 0; i < NUM_BUF; i++) begin : g_buf
        localparam logic [IRLENGTH-1:0] BUF_ADDR =
            IRLENGTH'((i == 0) ? DMI_ADDR : STB_BASE + i - 1);
        logic                  full_q;
        logic [READ_WIDTH-1:0] word_q;
        logic                  cap;

        // Capture needs !full and clear needs full, so they never meet on one buffer.
        assign cap = src_valid[i] && !full_q;

        always_ff @(posedge CLK_I or negedge RST_NI) begin
            if (!RST_NI)      full_q <= 1'b0;
            else if (cap)     full_q <= 1'b1;
            else if (clr[i])  full_q <= 1'b0;
        end

        always_ff @(posedge CLK_I) begin
            if (cap) word_q <= src_word[i];
        end

        assign buf_full[i] = full_q;
        assign sel_oh[i]   = (bus.READ_ADDRESS_I == BUF_ADDR);

        for (genvar b = 0; b < READ_WIDTH; b++) begin : g_col
            assign rd_col[b][i] = word_q[b] & sel_oh[i];
        end
    end

    for (genvar b = 0; b < READ_WIDTH; b++) begin : g_rd_or
        assign hit_word[b] = |rd_col[b];
    end

    assign hit_full = |(buf_full & sel_oh);
    assign mapped   = |sel_oh;

    for (genvar a = 0; a < ADDR_N; a++) begin : g_vaddr
        if (a == DMI_ADDR) begin : g_dmi
            assign bus.VALID_ADDRESS_O[a] = buf_full[0];
        end else if (a >= STB_BASE && a < STB_BASE + 2 * NUM_STB) begin : g_stb
            assign bus.VALID_ADDRESS_O[a] = buf_full[a - STB_BASE + 1];
        end else begin : g_none
            assign bus.VALID_ADDRESS_O[a] = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr       = '0;
        load      = 1'b0;
        load_word = '0;
        case (state_q)
            IDLE: begin
                if (bus.READ_READY_I) begin
                    if (!mapped) begin
                        load    = 1'b1;
                        state_d = SEND;
                    end else if (hit_full) begin
                        load      = 1'b1;
                        load_word = hit_word;
                        clr       = sel_oh;
                        state_d   = SEND;
                    end
                end
            end
            SEND: begin
                if (bus.READ_READY_I) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Response stage: word held stable for the whole SEND state.
    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            state_q      <= IDLE;
            resp_data_p0 <= '0;
        end else begin
            state_q <= state_d;
            if (load) resp_data_p0 <= load_word;
        end
    end

    assign bus.READ_VALID_O = (state_q == SEND);
    assign bus.READ_DATA_O  = resp_data_p0;
endmodule
